bus_arbiter: RTL and testbench

Round-robin arbiter that shares the system bus among four bus masters. Each master requests with an active-low request and receives a registered, one-hot, active-low grant. The arbiter tracks in-flight transactions from the shared address strobe and the muxed slave ready, so ownership never changes mid-transaction. It sits beside the slave-side read mux and drives the master-side select that routes the granted master onto the bus.

---
 rtl/bus_arbiter_pkg.sv | 16 +
 rtl/bus_arbiter_rr_pick.sv | 28 ++
 rtl/bus_arbiter.sv | 127 ++++++++++++
 tb/tb_bus_arbiter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared bus definitions for the system bus arbiter: polarity, widths, and the
// arbiter state encoding.
package bus_arbiter_pkg;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam int unsigned BUS_OWNER_W   = 2;
  localparam int unsigned BUS_MASTER_CH = 4;

  typedef enum logic {
    BUS_ARB_STATE_IDLE  = 1'b0,
    BUS_ARB_STATE_OWNED = 1'b1
  } bus_arb_state_e;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin pick: searches last+1, last+2, last+3, last and
// returns the first active request; excl_last drops the final (last) slot.
module bus_arb_rr_pick
  import bus_arbiter_pkg::*;
(
  input  logic [BUS_MASTER_CH-1:0] req,
  input  logic [BUS_OWNER_W-1:0]   last,
  input  logic                     excl_last,
  output logic [BUS_OWNER_W-1:0]   winner,
  output logic                     valid
);

  logic [BUS_OWNER_W-1:0] cand;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    cand   = last;
    for (int unsigned i = 1; i <= BUS_MASTER_CH; i++) begin
      cand = last + BUS_OWNER_W'(i);
      if (!valid && req[cand] && !(excl_last && (i == BUS_MASTER_CH))) begin
        winner = cand;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for four bus masters with active-low request/grant,
// transaction tracking from the address strobe and slave ready, and hold revoke.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned HOLD_MAX   = 16,
  parameter int unsigned HOLD_CNT_W = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   m0_req_,
  input  logic                   m1_req_,
  input  logic                   m2_req_,
  input  logic                   m3_req_,
  input  logic                   m_as_,
  input  logic                   m_rdy_,
  output logic                   m0_grnt_,
  output logic                   m1_grnt_,
  output logic                   m2_grnt_,
  output logic                   m3_grnt_,
  output logic [BUS_OWNER_W-1:0] owner,
  output logic                   busy
);

  bus_arb_state_e            state_q, state_d;
  logic [BUS_MASTER_CH-1:0]  grnt_q, grnt_d;
  logic [BUS_OWNER_W-1:0]    owner_q, owner_d;
  logic [BUS_OWNER_W-1:0]    last_q, last_d;
  logic                      busy_q, busy_d;
  logic                      inflight_q, inflight_d;
  logic [HOLD_CNT_W-1:0]     cnt_q, cnt_d;

  logic [BUS_MASTER_CH-1:0]  req;
  logic                      owned, pending, owner_req, hold_done, handover;
  logic [BUS_OWNER_W-1:0]    pick_last, pick_idx;
  logic                      pick_valid;

  assign req       = ~{m3_req_, m2_req_, m1_req_, m0_req_};
  assign owned     = (state_q == BUS_ARB_STATE_OWNED);
  assign pending   = inflight_q | (m_as_ == ENABLE_);
  assign owner_req = req[owner_q];
  assign hold_done = (HOLD_MAX != 0) && (cnt_q == HOLD_CNT_W'(HOLD_MAX));
  assign handover  = owned && !pending && (!owner_req || (hold_done && pick_valid));

  // While owned, searching from the owner with its own slot excluded is the
  // same as searching from the post-release value of last.
  assign pick_last = owned ? owner_q : last_q;

  bus_arb_rr_pick u_pick (
    .req       (req),
    .last      (pick_last),
    .excl_last (owned),
    .winner    (pick_idx),
    .valid     (pick_valid)
  );

  always_comb begin
    state_d    = state_q;
    grnt_d     = grnt_q;
    owner_d    = owner_q;
    last_d     = last_q;
    busy_d     = busy_q;
    cnt_d      = cnt_q;
    inflight_d = inflight_q;

    if (m_rdy_ == ENABLE_)     inflight_d = 1'b0;
    else if (m_as_ == ENABLE_) inflight_d = 1'b1;

    unique case (state_q)
      BUS_ARB_STATE_IDLE: begin
        cnt_d = '0;
        if (pick_valid) begin
          state_d          = BUS_ARB_STATE_OWNED;
          owner_d          = pick_idx;
          busy_d           = 1'b1;
          grnt_d           = '1;
          grnt_d[pick_idx] = ENABLE_;
        end
      end
      BUS_ARB_STATE_OWNED: begin
        if (handover) begin
          last_d = owner_q;
          cnt_d  = '0;
          grnt_d = '1;
          if (pick_valid) begin
            owner_d          = pick_idx;
            grnt_d[pick_idx] = ENABLE_;
          end else begin
            state_d = BUS_ARB_STATE_IDLE;
            busy_d  = 1'b0;
          end
        end else if (cnt_q < HOLD_CNT_W'(HOLD_MAX)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= BUS_ARB_STATE_IDLE;
      grnt_q     <= '1;
      owner_q    <= '0;
      last_q     <= '1;
      busy_q     <= 1'b0;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      grnt_q     <= grnt_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
    end
  end

  assign m0_grnt_ = grnt_q[0];
  assign m1_grnt_ = grnt_q[1];
  assign m2_grnt_ = grnt_q[2];
  assign m3_grnt_ = grnt_q[3];
  assign owner    = owner_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: a rule-level arbitration model checked every cycle,
// plus directed scenarios with literal expected grants.
module tb_bus_arbiter;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req_n;
  logic       as_n, rdy_n;
  logic [3:0] grnt_n;
  logic [1:0] owner;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  bus_arbiter #(.HOLD_MAX(HOLD), .HOLD_CNT_W(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .m0_req_  (req_n[0]),
    .m1_req_  (req_n[1]),
    .m2_req_  (req_n[2]),
    .m3_req_  (req_n[3]),
    .m_as_    (as_n),
    .m_rdy_   (rdy_n),
    .m0_grnt_ (grnt_n[0]),
    .m1_grnt_ (grnt_n[1]),
    .m2_grnt_ (grnt_n[2]),
    .m3_grnt_ (grnt_n[3]),
    .owner    (owner),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  // Model state: who holds the bus, who released last, owned cycles, open transfer.
  int m_busy = 0, m_own = 0, m_last = 3, m_cnt = 0, m_open = 0;

  function automatic int rr_winner(input int from, input int excl, input logic [3:0] rq_n);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (from + k) % 4;
      if (c != excl && rq_n[c] == 1'b0) return c;
    end
    return -1;
  endfunction

  task automatic model_step();
    int other, nxt_open;
    if (reset) begin
      m_busy = 0; m_own = 0; m_last = 3; m_cnt = 0; m_open = 0;
    end else begin
      nxt_open = (rdy_n == 1'b0) ? 0 : ((as_n == 1'b0) ? 1 : m_open);
      if (m_busy == 0) begin
        other = rr_winner(m_last, -1, req_n);
        if (other >= 0) begin m_busy = 1; m_own = other; end
        m_cnt = 0;
      end else begin
        other = rr_winner(m_own, m_own, req_n);
        if (!(m_open == 1 || as_n == 1'b0) &&
            (req_n[m_own] == 1'b1 || (m_cnt == HOLD && other >= 0))) begin
          m_last = m_own;
          m_cnt  = 0;
          if (other >= 0) m_own = other;
          else m_busy = 0;
        end else if (m_cnt < HOLD) begin
          m_cnt++;
        end
      end
      m_open = nxt_open;
    end
  endtask

  always @(posedge clk) begin
    logic [3:0] eg;
    model_step();
    #1;
    eg = 4'hF;
    if (m_busy != 0) eg[m_own] = 1'b0;
    chk("model_grnt", int'(grnt_n), int'(eg));
    chk("model_busy", int'(busy), m_busy);
    if (m_busy != 0) chk("model_owner", int'(owner), m_own);
  end

  task automatic do_reset();
    reset = 1'b1; req_n = '1; as_n = 1'b1; rdy_n = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_n = '1; as_n = 1'b1; rdy_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_grnt", int'(grnt_n), 'hF);
    chk("rst_busy", int'(busy), 0);
    chk("rst_owner", int'(owner), 0);

    // single requester m1
    reset = 1'b0;
    @(negedge clk);
    req_n[1] = 1'b0;
    @(negedge clk);
    chk("t1_grnt", int'(grnt_n), 'b1101);
    chk("t1_owner", int'(owner), 1);
    chk("t1_busy", int'(busy), 1);
    @(negedge clk);
    chk("t1_hold", int'(grnt_n), 'b1101);
    req_n[1] = 1'b1;
    @(negedge clk);
    chk("t1_release", int'(grnt_n), 'hF);

    // m0 and m2 together, m0 releases with no gap
    do_reset();
    req_n[0] = 1'b0; req_n[2] = 1'b0;
    @(negedge clk);
    chk("t2_first", int'(grnt_n), 'b1110);
    req_n[0] = 1'b1;
    @(negedge clk);
    chk("t2_handover", int'(grnt_n), 'b1011);
    req_n[2] = 1'b1;
    repeat (2) @(negedge clk);

    // revoke after hold limit
    do_reset();
    req_n[0] = 1'b0;
    @(negedge clk);
    req_n[3] = 1'b0;
    repeat (4) @(negedge clk);
    chk("t3_hold", int'(grnt_n), 'b1110);
    @(negedge clk);
    chk("t3_revoke", int'(grnt_n), 'b0111);
    repeat (7) @(negedge clk);
    req_n = '1;
    repeat (2) @(negedge clk);

    // revoke deferred by a waited transfer
    do_reset();
    req_n[0] = 1'b0;
    @(negedge clk);
    req_n[3] = 1'b0;
    repeat (4) @(negedge clk);
    as_n = 1'b0;
    @(negedge clk);
    chk("t4_as_hold", int'(grnt_n), 'b1110);
    as_n = 1'b1;
    repeat (2) @(negedge clk);
    rdy_n = 1'b0;
    @(negedge clk);
    rdy_n = 1'b1;
    chk("t4_deferred", int'(grnt_n), 'b1110);
    @(negedge clk);
    chk("t4_revoke", int'(grnt_n), 'b0111);
    req_n = '1;
    repeat (2) @(negedge clk);

    // all four request, each does one zero-wait transfer then releases
    do_reset();
    req_n = 4'b0000;
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      chk("t5_order", int'(owner), k % 4);
      chk("t5_busy", int'(busy), 1);
      as_n = 1'b0; rdy_n = 1'b0;
      @(negedge clk);
      as_n = 1'b1; rdy_n = 1'b1;
      req_n[k % 4] = 1'b1;
      @(negedge clk);
      req_n[k % 4] = 1'b0;
    end
    req_n = '1;
    repeat (2) @(negedge clk);

    // reset while m2 owns with a transfer in flight
    do_reset();
    req_n[2] = 1'b0;
    @(negedge clk);
    chk("t6_grant", int'(grnt_n), 'b1011);
    as_n = 1'b0;
    @(negedge clk);
    as_n = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    chk("t6_rst_grnt", int'(grnt_n), 'hF);
    chk("t6_rst_busy", int'(busy), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_regrant", int'(grnt_n), 'b1011);
    req_n = '1;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
